// File: rtl/int_controller.sv
// Eight-pin interrupt controller: synchronises INTS, latches edge/level requests
// into PENDING, masks them onto INT0 (sources 0-3) and INT1 (sources 4-7).
module int_controller #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] EDGE_RESET  = 8'hFF,
    parameter logic [7:0] MASK_RESET  = 8'h00
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [7:0]  INTS,
    input  logic        SEL,
    input  logic [1:0]  ADDR,
    input  logic [15:0] CPU_DOUT,
    input  logic        RDN,
    input  logic        WR0N,
    input  logic        WR1N,
    output logic [15:0] DOUT,
    output logic        INT0,
    output logic        INT1
);

    // A single-stage synchroniser is never safe, so anything below two is raised to two.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_VECTOR = 2'd2;
    localparam logic [1:0] ADDR_MODE   = 2'd3;

    logic [7:0]  r_sync [STAGES];
    logic [7:0]  r_prev;
    logic [7:0]  r_pending;
    logic [7:0]  r_mask;
    logic [7:0]  r_mode;
    logic        r_int0;
    logic        r_int1;

    logic [7:0]  w_s;
    logic [7:0]  w_set;
    logic [7:0]  w_clr;
    logic [7:0]  w_active;
    logic        w_wr;
    logic [2:0]  w_vec_idx;
    logic [15:0] w_vector;
    logic [15:0] w_rd_data;
    logic        w_unused;

    // The high-byte strobe and the upper write byte reach no register.
    assign w_unused = &{1'b0, WR1N, CPU_DOUT[15:8]};

    assign w_s      = r_sync[STAGES-1];
    assign w_wr     = SEL & ~WR0N;
    assign w_clr    = {8{w_wr && (ADDR == ADDR_STATUS)}} & CPU_DOUT[7:0];
    assign w_set    = (w_s & ~r_prev & r_mode) | (w_s & ~r_mode);
    assign w_active = r_pending & r_mask;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= 8'h00;
            end
        end else begin
            r_sync[0] <= INTS;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // prev resets low, so a pin already high at reset release looks like a rising edge.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_prev    <= 8'h00;
            r_pending <= 8'h00;
        end else begin
            r_prev    <= w_s;
            r_pending <= w_set | (r_pending & ~w_clr);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_mask <= MASK_RESET;
            r_mode <= EDGE_RESET;
        end else begin
            if (w_wr && (ADDR == ADDR_MASK)) begin
                r_mask <= CPU_DOUT[7:0];
            end
            if (w_wr && (ADDR == ADDR_MODE)) begin
                r_mode <= CPU_DOUT[7:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_int0 <= 1'b0;
            r_int1 <= 1'b0;
        end else begin
            r_int0 <= |w_active[3:0];
            r_int1 <= |w_active[7:4];
        end
    end

    assign INT0 = r_int0;
    assign INT1 = r_int1;

    // Descending scan so the lowest active index is the one left standing.
    always_comb begin
        w_vec_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec_idx = 3'(i);
            end
        end
    end

    assign w_vector = {|w_active, 12'h000, w_vec_idx};

    always_comb begin
        w_rd_data = 16'h0000;
        case (ADDR)
            ADDR_STATUS: w_rd_data = {8'h00, r_pending};
            ADDR_MASK:   w_rd_data = {8'h00, r_mask};
            ADDR_VECTOR: w_rd_data = w_vector;
            ADDR_MODE:   w_rd_data = {8'h00, r_mode};
            default:     w_rd_data = 16'h0000;
        endcase
    end

    assign DOUT = (RESETN && SEL && !RDN) ? w_rd_data : 16'h0000;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: inputs change on the falling edge,
// outputs are checked on the falling edge (or 1 ns after a rising edge).
module tb_int_controller;

    logic        CLK;
    logic        RESETN;
    logic [7:0]  INTS;
    logic        SEL;
    logic [1:0]  ADDR;
    logic [15:0] CPU_DOUT;
    logic        RDN;
    logic        WR0N;
    logic        WR1N;
    logic [15:0] DOUT;
    logic        INT0;
    logic        INT1;

    int total = 0;
    int bad   = 0;

    int_controller #(
        .SYNC_STAGES (2),
        .EDGE_RESET  (8'hFF),
        .MASK_RESET  (8'h00)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .INTS     (INTS),
        .SEL      (SEL),
        .ADDR     (ADDR),
        .CPU_DOUT (CPU_DOUT),
        .RDN      (RDN),
        .WR0N     (WR0N),
        .WR1N     (WR1N),
        .DOUT     (DOUT),
        .INT0     (INT0),
        .INT1     (INT1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
        SEL  = 1'b1;
        RDN  = 1'b0;
        ADDR = a;
        #1;
        check(tag, DOUT, exp);
        SEL  = 1'b0;
        RDN  = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        SEL      = 1'b1;
        ADDR     = a;
        CPU_DOUT = d;
        WR0N     = 1'b0;
        tick();
        SEL      = 1'b0;
        WR0N     = 1'b1;
    endtask

    task automatic check_ints(input string tag, input logic e0, input logic e1);
        check({tag, "_int0"}, {15'h0, INT0}, {15'h0, e0});
        check({tag, "_int1"}, {15'h0, INT1}, {15'h0, e1});
    endtask

    initial begin
        RESETN   = 1'b0;
        INTS     = 8'h00;
        SEL      = 1'b0;
        ADDR     = 2'd0;
        CPU_DOUT = 16'h0000;
        RDN      = 1'b1;
        WR0N     = 1'b1;
        WR1N     = 1'b1;

        // Reset values
        tick();
        tick();
        check_ints("rst", 1'b0, 1'b0);
        rd(2'd3, 16'h0000, "rst_dout_gated");
        RESETN = 1'b1;
        tick();
        rd(2'd3, 16'h00FF, "rst_mode");
        rd(2'd1, 16'h0000, "rst_mask");
        rd(2'd0, 16'h0000, "rst_status");

        // Edge latency on source 0
        wr(2'd1, 16'h0001);
        INTS[0] = 1'b1;
        tick();                       // E0
        INTS[0] = 1'b0;
        tick();                       // E1
        tick();                       // E2
        check_ints("lat_e2", 1'b0, 1'b0);
        rd(2'd0, 16'h0001, "lat_status");
        tick();                       // E3
        check_ints("lat_e3", 1'b1, 1'b0);
        wr(2'd0, 16'h0001);
        check_ints("clr_c", 1'b1, 1'b0);
        rd(2'd0, 16'h0000, "clr_status");
        tick();
        check_ints("clr_c1", 1'b0, 1'b0);

        // Masked sources still latch; VECTOR picks the lowest active one
        wr(2'd1, 16'h0000);
        INTS = 8'h44;
        tick();
        tick();
        tick();
        tick();
        check_ints("masked", 1'b0, 1'b0);
        rd(2'd0, 16'h0044, "masked_status");
        rd(2'd2, 16'h0000, "masked_vector");
        wr(2'd1, 16'h00FF);
        check_ints("unmask_c", 1'b0, 1'b0);
        rd(2'd2, 16'h8002, "unmask_vector");
        tick();
        check_ints("unmask_c1", 1'b1, 1'b1);
        rd(2'd2, 16'h8002, "vector_no_side_effect");
        INTS = 8'h00;
        wr(2'd0, 16'h00FF);
        rd(2'd0, 16'h0000, "clear_all");
        tick();
        check_ints("clear_all", 1'b0, 1'b0);

        // Level mode on source 4
        wr(2'd3, 16'h00EF);
        wr(2'd1, 16'h0010);
        INTS[4] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check_ints("lvl_set", 1'b0, 1'b1);
        wr(2'd0, 16'h0010);
        rd(2'd0, 16'h0010, "lvl_clr_held");
        tick();
        check_ints("lvl_clr_held", 1'b0, 1'b1);
        INTS[4] = 1'b0;
        tick();
        tick();
        rd(2'd0, 16'h0010, "lvl_still_pending");
        wr(2'd0, 16'h0010);
        rd(2'd0, 16'h0000, "lvl_cleared");
        tick();
        check_ints("lvl_cleared", 1'b0, 1'b0);

        // Set and clear of source 3 on the same edge: set wins
        wr(2'd3, 16'h00FF);
        wr(2'd1, 16'h0008);
        INTS[3] = 1'b1;
        tick();                       // E0
        tick();                       // E1
        rd(2'd0, 16'h0000, "coll_before");
        wr(2'd0, 16'h0008);           // clear lands on E2
        rd(2'd0, 16'h0008, "coll_set_wins");
        tick();
        check_ints("coll", 1'b1, 1'b0);

        // Async reset with everything pending
        wr(2'd3, 16'h0000);
        wr(2'd1, 16'h00FF);
        INTS = 8'hFF;
        tick();
        tick();
        tick();
        tick();
        rd(2'd0, 16'h00FF, "full_status");
        check_ints("full", 1'b1, 1'b1);
        #2;
        RESETN = 1'b0;
        #1;
        check_ints("async_rst", 1'b0, 1'b0);
        INTS = 8'h20;                 // pin 5 high across release
        @(negedge CLK);
        RESETN = 1'b1;
        rd(2'd1, 16'h0000, "post_rst_mask");
        rd(2'd3, 16'h00FF, "post_rst_mode");
        rd(2'd0, 16'h0000, "post_rst_status");
        tick();
        tick();
        tick();
        rd(2'd0, 16'h0020, "high_at_release_edge");
        INTS = 8'h00;

        // Read and write of MASK in the same cycle; high-byte strobe is inert
        SEL      = 1'b1;
        ADDR     = 2'd1;
        CPU_DOUT = 16'hAB55;
        WR0N     = 1'b0;
        RDN      = 1'b0;
        #1;
        check("rw_pre_edge", DOUT, 16'h0000);
        @(posedge CLK);
        #1;
        check("rw_post_edge", DOUT, 16'h0055);
        @(negedge CLK);
        WR0N     = 1'b1;
        RDN      = 1'b1;
        SEL      = 1'b0;
        SEL      = 1'b1;
        CPU_DOUT = 16'h00AA;
        WR1N     = 1'b0;
        tick();
        SEL      = 1'b0;
        WR1N     = 1'b1;
        rd(2'd1, 16'h0055, "wr1n_ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Interrupt controller between the eight external interrupt pins (INTS0..INTS7) and the core's two interrupt request inputs (INT0, INT1).
- Synchronises and edge- or level-detects each source, latches pending requests, and applies a CPU-writable enable mask.
- Collapses sources 0-3 onto INT0 and 4-7 onto INT1.
- Exposes a four-register window on the CPU data bus, decoded by mcuResources through SEL.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchroniser (minimum 2).
- EDGE_RESET, 8'hFF: reset value of the MODE register (1 = rising-edge, 0 = level).
- MASK_RESET, 8'h00: reset value of the MASK register.

Ports:
- CLK  in  1  system clock; all state on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- INTS  in  8  raw external interrupt pins, asynchronous; bit n = INTSn.
- SEL  in  1  register window selected (address decode from mcuResources).
- ADDR  in  2  register index.
- CPU_DOUT  in  16  write data from the core.
- RDN  in  1  active-low read strobe.
- WR0N  in  1  active-low low-byte write strobe.
- WR1N  in  1  active-low high-byte write strobe; no register bits respond to it.
- DOUT  out  16  read data.
- INT0  out  1  request to the core for sources 0-3.
- INT1  out  1  request to the core for sources 4-7.

Behaviour:
- Reset (RESETN=0, asynchronous): synchroniser, prev, PENDING, INT0 and INT1 all clear to 0; MASK=MASK_RESET; MODE=EDGE_RESET. DOUT is combinational and reads 0 while RESETN=0.
- Synchroniser: s[n] is the SYNC_STAGES-deep registered copy of INTS[n]. prev[n] is s[n] delayed by one cycle.
- Set condition, edge mode (MODE[n]=1): set[n] = s[n] & ~prev[n].
- Set condition, level mode (MODE[n]=0): set[n] = s[n].
- A pin already high when RESETN releases counts as a rising edge.
- PENDING[n] next value: set[n] | (PENDING[n] & ~clr[n]).
  - Set wins over clear in the same cycle.
  - In level mode a clear has no lasting effect while s[n]=1.
- Write: clr[n] = SEL & ~WR0N & (ADDR==0) & CPU_DOUT[n], evaluated at every rising edge.
  - Writes apply at each rising edge while the strobe is low; repeats are idempotent.
- Outputs, registered:
  - INT0 <= |(PENDING[3:0] & MASK[3:0])
  - INT1 <= |(PENDING[7:4] & MASK[7:4])
- Latency (SYNC_STAGES=2): pin rises before edge E0 -> s at E1 -> PENDING at E2 -> INTx at E3. Clearing at edge C drops INTx at C+1.
- Masking: MASK gates only INTx. Masked sources still latch PENDING, and unmasking a pending source raises INTx on the next edge.
- Register map (SEL=1):
  - ADDR 0 STATUS: read {8'h00, PENDING}; write-1-to-clear bits [7:0].
  - ADDR 1 MASK: read/write, bits [7:0].
  - ADDR 2 VECTOR: read only, side-effect free.
    - Bit 15 = any (PENDING & MASK) nonzero.
    - Bits [2:0] = lowest index n with PENDING[n] & MASK[n]; 0 if none.
    - All other bits 0.
  - ADDR 3 MODE: read/write, bits [7:0].
- Read data: DOUT = selected register when SEL & ~RDN, else 16'h0000. Reads are combinational from current register values. Writes to read-only bits are ignored.
- Simultaneous write and read of the same register: DOUT shows the pre-edge value.
- Reset mid-operation: in-flight pins and pending requests are discarded and INTx drops immediately.

Test Plan:
- Reset values: hold RESETN=0, check DOUT/INT0/INT1 = 0. Release, read MODE -> 16'h00FF, MASK -> 16'h0000.
- Edge latency: MASK=8'h01, pulse INTS[0] high for 1 cycle before E0 -> INT0=1 at E3. STATUS reads 16'h0001. Write 16'h0001 to ADDR 0 -> INT0=0 next edge. INT1 stays 0 throughout.
- Masked latch and priority: MASK=0, assert edges on INTS[6] and INTS[2] -> INT0=INT1=0, STATUS=16'h0044, VECTOR=16'h0000. Write MASK=8'hFF -> INT0=INT1=1 one edge later, VECTOR=16'h8002.
- Level mode: MODE=8'hEF, hold INTS[4]=1, MASK=8'h10. Write-1-to-clear bit 4 -> PENDING[4] and INT1 stay 1. Drop INTS[4], then clear -> INT1=0.
- Set-vs-clear collision: arrange a new INTS[3] edge to reach the set condition on the same edge as the ADDR 0 write of 16'h0008 -> PENDING[3] remains 1.
- Async reset mid-operation: with PENDING=8'hFF and INT0=INT1=1, assert RESETN=0 between clock edges -> INT0=INT1=0 immediately. After release, MASK=8'h00 again.
